// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round controller.
package game_pkg;

    localparam int BOX_W   = 2;
    localparam int SCORE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SHOW,
        ST_GAP,
        ST_FIN
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle tick every TICK_DIV clocks.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap; runs regardless of game state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/round_controller.sv
// Round controller for the whack-a-box game: lights a random box per round,
// scores correct hits, counts timeouts as misses.
// Build option: ROUND_NO_REPEAT_EN rejects a new target equal to the previous
// one (up to 3 resamples, then forces previous+1).
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start, busy low
// ST_SAMPLE | latch box_in as the new target, bump round count
// ST_SHOW   | target lit, waiting for a hit or SHOW_MS ticks
// ST_GAP    | target dark for GAP_MS ticks
// ST_FIN    | one-cycle done pulse, then back to idle
module round_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int SHOW_MS  = 1000,
    parameter int GAP_MS   = 300,
    parameter int ROUNDS   = 20
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic [BOX_W-1:0]   box_in,
    input  logic               hit_valid,
    input  logic [BOX_W-1:0]   hit_box,
    output logic [BOX_W-1:0]   target,
    output logic               target_valid,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] misses,
    output logic               busy,
    output logic               done
);

    localparam int MS_MAX = (SHOW_MS > GAP_MS) ? SHOW_MS : GAP_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam logic [MS_W-1:0] SHOW_LAST = MS_W'(SHOW_MS - 1);
    localparam logic [MS_W-1:0] GAP_LAST  = MS_W'(GAP_MS - 1);
    localparam logic [7:0]      ROUNDS_C  = 8'(ROUNDS);

    state_t            r_state;
    logic [7:0]        r_round;
    logic [MS_W-1:0]   r_ms;
    logic [1:0]        r_sync;
    logic              w_run;
    logic              w_tick;
    logic              w_hit;
    logic              w_retry;
    logic [BOX_W-1:0]  w_box;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .tick     (w_tick)
    );

    // Reset asserts asynchronously but the FSM only starts moving two edges
    // after release, so a release near an edge cannot split the state bits.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_run = r_sync[1];
    assign w_hit = hit_valid && (hit_box == target);

`ifdef ROUND_NO_REPEAT_EN
    logic [1:0] r_retry;
    logic       w_repeat;

    // target still holds the previous round's box while in SAMPLE.
    assign w_repeat = (r_round != '0) && (box_in == target);
    assign w_retry  = w_repeat && (r_retry != 2'd3);
    assign w_box    = w_repeat ? target + BOX_W'(1) : box_in;

    // Resample counter, cleared whenever a target is accepted.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_retry <= 2'd0;
        end else if (w_run && r_state == ST_SAMPLE) begin
            r_retry <= w_retry ? r_retry + 2'd1 : 2'd0;
        end
    end
`else
    assign w_retry = 1'b0;
    assign w_box   = box_in;
`endif

    // Game sequencing with all outputs registered.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            target       <= '0;
            target_valid <= 1'b0;
            score        <= '0;
            misses       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            r_round      <= '0;
            r_ms         <= '0;
        end else if (w_run) begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        score   <= '0;
                        misses  <= '0;
                        r_round <= '0;
                        r_ms    <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (!w_retry) begin
                        target       <= w_box;
                        target_valid <= 1'b1;
                        r_round      <= r_round + 8'd1;
                        r_ms         <= '0;
                        r_state      <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    // A correct hit wins over a timeout landing on the same cycle.
                    if (w_hit) begin
                        score        <= sat_inc(score);
                        target_valid <= 1'b0;
                        r_ms         <= '0;
                        r_state      <= ST_GAP;
                    end else if (w_tick) begin
                        if (r_ms == SHOW_LAST) begin
                            misses       <= sat_inc(misses);
                            target_valid <= 1'b0;
                            r_ms         <= '0;
                            r_state      <= ST_GAP;
                        end else begin
                            r_ms <= r_ms + MS_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_ms == GAP_LAST) begin
                            r_ms <= '0;
                            if (r_round == ROUNDS_C) begin
                                done    <= 1'b1;
                                r_state <= ST_FIN;
                            end else begin
                                r_state <= ST_SAMPLE;
                            end
                        end else begin
                            r_ms <= r_ms + MS_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    target_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, CLOCK_50 cycles per 1 ms tick.
REQ-002 SHALL have parameter SHOW_MS, default 1000, target display window in ticks.
REQ-003 SHALL have parameter GAP_MS, default 300, blank interval between targets in ticks.
REQ-004 SHALL have parameter ROUNDS, default 20, targets per game, range 1-255.
REQ-005 SHALL have port CLOCK_50  in  1  sole clock, rising edge.
REQ-006 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  one-cycle pulse, begins a game.
REQ-008 SHALL have port box_in  in  2  random box index from the mapper, sampled, never registered continuously.
REQ-009 SHALL have port hit_valid  in  1  one-cycle player-hit pulse.
REQ-010 SHALL have port hit_box  in  2  box struck, qualified by hit_valid.
REQ-011 SHALL have ports target  out  2, target_valid  out  1: current lit box.
REQ-012 SHALL have ports score  out  8, misses  out  8, busy  out  1, done  out  1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE, SAMPLE, SHOW, GAP, FIN.
REQ-014 IDLE: on start, SHALL clear score, misses, round count, ms counter and enter SAMPLE next cycle; busy=1 in every state except IDLE.
REQ-015 SAMPLE: SHALL latch box_in into target, increment round count, clear ms counter, enter SHOW next cycle.
REQ-016 SHOW: target_valid=1; ms counter SHALL increment once per tick.
REQ-017 SHOW: hit_valid with hit_box==target SHALL increment score (saturating at 255) and enter GAP next cycle.
REQ-018 SHOW: hit_valid with hit_box!=target SHALL be ignored; no score or miss change.
REQ-019 SHOW: when ms counter reaches SHOW_MS without a correct hit, SHALL increment misses (saturating at 255) and enter GAP.
REQ-020 Correct hit in the same cycle as timeout SHALL count as a hit only.
REQ-021 GAP: target_valid=0, ms counter cleared on entry, after GAP_MS ticks SHALL enter FIN if round count==ROUNDS, else SAMPLE.
REQ-022 FIN: SHALL pulse done for exactly one cycle and return to IDLE; score and misses SHALL hold until next start.
REQ-023 start while busy=1 SHALL be ignored; hit_valid outside SHOW SHALL be ignored.
REQ-024 Tick prescaler SHALL free-run from reset, wrapping at TICK_DIV-1; first tick of a window may be short by up to one tick period.

Reset
REQ-025 resetn low SHALL immediately force IDLE, target=0, target_valid=0, score=0, misses=0, busy=0, done=0, round count=0, prescaler=0, including mid-game.
REQ-026 Release SHALL be synchronised internally; first state change no earlier than second rising edge after release.

Configuration
REQ-027 Macro ROUND_NO_REPEAT_EN defined: in SAMPLE, if box_in equals the previous target (not first round), SHALL remain in SAMPLE and resample next cycle, up to 3 retries, then use (previous+1) mod 4.
REQ-028 Macro undefined: SHALL accept box_in unconditionally; SAMPLE always exactly one cycle.

Structure
REQ-029 Shared package game_pkg SHALL hold the FSM state enum, BOX_W=2 and score width constant.
REQ-030 Prescaler SHALL be sub-module ms_tick_gen (CLOCK_50, resetn, tick out).

Verification (TICK_DIV=4, SHOW_MS=5, GAP_MS=2, ROUNDS=3)
REQ-031 Reset mid-SHOW with target_valid=1 -> target_valid, score, busy read 0 before next clock edge.
REQ-032 start, box_in=2, hit_box=2 pulse on tick 2 of SHOW -> score=1, target_valid=0 next cycle.
REQ-033 start, no hits for full game -> misses=3, score=0, single done pulse, busy=0 after.
REQ-034 hit_box=1 while target=3, then timeout -> score=0, misses=1.
REQ-035 Correct hit on the timeout cycle -> score=1, misses=0.
REQ-036 ROUND_NO_REPEAT_EN, box_in held at 1 -> round 2 target=2 after 3 retries; without macro -> target=1.
